// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Command-driven initiator for the external 4-bit ALU. Buffers
//            commands in a small FIFO, drives ALU operands from an internal
//            accumulator/carry, captures the ALU result and returns it on a
//            valid/ready response stream.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [W+4:0] cmd_data_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_data_o,
  output logic         res_cout_o,
  output logic [W-1:0] alu_a_o,
  output logic [W-1:0] alu_b_o,
  output logic         alu_cin_o,
  output logic [1:0]   alu_opcode_o,
  output logic         alu_pass_a_o,
  output logic         alu_pass_b_o,
  input  logic [W-1:0] alu_out_i,
  input  logic         alu_cout_i
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = W + 5;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

  localparam logic [1:0] MODE_OP   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_READ = 2'b10;
  localparam logic [1:0] MODE_CLRC = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [CW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  state_t        state_q;

  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign cmd_ready_o = !full;
  assign push        = cmd_valid_i && !full;
  // Pop is gated by the registered count, so a freshly pushed command is
  // never consumed in the cycle it arrives.
  assign pop         = (state_q == S_IDLE) && !empty;

  // Occupancy moves only when exactly one of push/pop fires.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Entry storage; contents are only meaningful under count_q, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data_i;
  end

  // Head-of-queue field decode.
  logic [CW-1:0] head;
  logic [1:0]    head_mode;
  logic [1:0]    head_opcode;
  logic          head_use_carry;
  logic [W-1:0]  head_imm;

  assign head           = mem_q[rd_ptr_q];
  assign head_mode      = head[W+4:W+3];
  assign head_opcode    = head[W+2:W+1];
  assign head_use_carry = head[W];
  assign head_imm       = head[W-1:0];

  // --------------------------------------------------------------------------
  // Sequencer FSM with registered ALU drive and response outputs
  // --------------------------------------------------------------------------
  logic [1:0]   mode_q;
  logic [W-1:0] acc_q;
  logic         carry_q;
  logic         res_valid_q;
  logic [W-1:0] res_data_q;
  logic         res_cout_q;
  logic [W-1:0] alu_a_q;
  logic [W-1:0] alu_b_q;
  logic         alu_cin_q;
  logic [1:0]   alu_opcode_q;
  logic         alu_pass_a_q;
  logic         alu_pass_b_q;

  // One command at a time: pop and drive, capture the ALU result, then hold
  // the response until accepted. ALU drive returns to zero between commands,
  // so only the fields a mode uses need to be loaded in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_OP;
      acc_q        <= '0;
      carry_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_cout_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      alu_opcode_q <= 2'b00;
      alu_pass_a_q <= 1'b0;
      alu_pass_b_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            mode_q  <= head_mode;
            state_q <= S_DRIVE;
            unique case (head_mode)
              MODE_OP: begin
                alu_a_q      <= acc_q;
                alu_b_q      <= head_imm;
                alu_cin_q    <= head_use_carry & carry_q;
                alu_opcode_q <= head_opcode;
              end
              MODE_LOAD: begin
                alu_pass_b_q <= 1'b1;
                alu_b_q      <= head_imm;
              end
              MODE_READ: begin
                alu_pass_a_q <= 1'b1;
                alu_a_q      <= acc_q;
              end
              default: begin
                // CLRC leaves the ALU idle; its result is forced at capture.
              end
            endcase
          end
        end
        S_DRIVE: begin
          if (mode_q == MODE_CLRC) begin
            carry_q    <= 1'b0;
            res_data_q <= acc_q;
            res_cout_q <= 1'b0;
          end else begin
            acc_q      <= alu_out_i;
            carry_q    <= alu_cout_i;
            res_data_q <= alu_out_i;
            res_cout_q <= alu_cout_i;
          end
          res_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready_i) begin
            res_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_opcode_q <= 2'b00;
            alu_pass_a_q <= 1'b0;
            alu_pass_b_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_cout_o   = res_cout_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_cin_o    = alu_cin_q;
  assign alu_opcode_o = alu_opcode_q;
  assign alu_pass_a_o = alu_pass_a_q;
  assign alu_pass_b_o = alu_pass_b_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Self-checking bench for alu_cmd_sequencer with a behavioural
//            ALU stub and a command-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [8:0] cmd_data_i = '0;
  logic       res_valid_o;
  logic       res_ready_i = 1'b0;
  logic [3:0] res_data_o;
  logic       res_cout_o;
  logic [3:0] alu_a_o;
  logic [3:0] alu_b_o;
  logic       alu_cin_o;
  logic [1:0] alu_opcode_o;
  logic       alu_pass_a_o;
  logic       alu_pass_b_o;
  logic [3:0] alu_out_i;
  logic       alu_cout_i;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: accumulator, carry, expected responses in order.
  logic [3:0] m_acc   = '0;
  logic       m_carry = 1'b0;
  logic [4:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .W(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_data_i   (cmd_data_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_cout_o   (res_cout_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_cin_o    (alu_cin_o),
    .alu_opcode_o (alu_opcode_o),
    .alu_pass_a_o (alu_pass_a_o),
    .alu_pass_b_o (alu_pass_b_o),
    .alu_out_i    (alu_out_i),
    .alu_cout_i   (alu_cout_i)
  );

  // External ALU: 00 AND, 01 ADD+cin, 10 SUB-borrow (bit4 = borrow), 11 a>b.
  function automatic logic [4:0] alu_fn(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
    case (op)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a} + {1'b0, b} + {4'b0, cin};
      2'b10:   return {1'b0, a} - {1'b0, b} - {4'b0, cin};
      default: return (a > b) ? 5'd1 : 5'd0;
    endcase
  endfunction

  logic [4:0] alu_r;
  always_comb begin
    if (alu_pass_b_o)      alu_r = {1'b0, alu_b_o};
    else if (alu_pass_a_o) alu_r = {1'b0, alu_a_o};
    else                   alu_r = alu_fn(alu_opcode_o, alu_a_o, alu_b_o, alu_cin_o);
  end
  assign alu_out_i  = alu_r[3:0];
  assign alu_cout_i = alu_r[4];

  function automatic logic [8:0] mk(input logic [1:0] mode, input logic [1:0] op,
                                    input logic uc, input logic [3:0] imm);
    return {mode, op, uc, imm};
  endfunction

  // Apply one accepted command to the model and queue its expected response.
  task automatic model_push(input logic [8:0] c);
    logic [4:0] r;
    case (c[8:7])
      2'b00:   r = alu_fn(c[6:5], m_acc, c[3:0], c[4] & m_carry);
      2'b01:   r = {1'b0, c[3:0]};
      default: r = {1'b0, m_acc};
    endcase
    if (c[8:7] != 2'b11) m_acc = r[3:0];
    m_carry = r[4];
    exp_q.push_back(r);
  endtask

  // Offer a command until accepted or the cycle budget expires.
  task automatic push(input logic [8:0] c, input int max_wait, output bit accepted);
    accepted    = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_data_i  = c;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk_i);
      if (cmd_ready_o) begin
        accepted = 1'b1;
        model_push(c);
        break;
      end
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    if (!accepted) begin
      n_vec++; n_miss++;
      $display("FAIL push_timeout: cmd %h not accepted, required acceptance", c);
    end
  endtask

  // Accept one response and return it as {cout,data}.
  task automatic collect(output logic [4:0] r, output bit ok);
    ok = 1'b0;
    r  = '0;
    res_ready_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (res_valid_o) begin
        r  = {res_cout_o, res_data_o};
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_i); #1;
    res_ready_i = 1'b0;
    if (!ok) begin
      n_vec++; n_miss++;
      $display("FAIL collect_timeout: res_valid 0, required 1");
    end
  endtask

  task automatic assert_reset();
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    res_ready_i = 1'b0;
    m_acc       = '0;
    m_carry     = 1'b0;
    exp_q.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    assert_reset();
    release_reset();
    @(negedge clk_i);
    n_vec++;
    if (cmd_ready_o !== 1'b1) begin n_miss++; $display("FAIL rst_cmd_ready: got %b, required 1", cmd_ready_o); end
    n_vec++;
    if (res_valid_o !== 1'b0) begin n_miss++; $display("FAIL rst_res_valid: got %b, required 0", res_valid_o); end
    n_vec++;
    if ({res_cout_o, res_data_o} !== 5'h00) begin n_miss++; $display("FAIL rst_res: got %h, required 00", {res_cout_o, res_data_o}); end
    n_vec++;
    if ({alu_a_o, alu_b_o, alu_cin_o, alu_opcode_o, alu_pass_a_o, alu_pass_b_o} !== 13'h0) begin
      n_miss++; $display("FAIL rst_alu: got %h, required 0", {alu_a_o, alu_b_o, alu_cin_o, alu_opcode_o, alu_pass_a_o, alu_pass_b_o});
    end
    n_vec++;
    if (dut.count_q !== '0) begin n_miss++; $display("FAIL rst_count: got %0d, required 0", dut.count_q); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_directed();
    logic [8:0] cmds [8];
    logic [4:0] want [8];
    logic [4:0] got;
    bit ok, acc;
    cmds[0] = mk(2'b01, 2'b00, 1'b0, 4'hA); want[0] = 5'h0A;
    cmds[1] = mk(2'b00, 2'b01, 1'b0, 4'h7); want[1] = 5'h11;
    cmds[2] = mk(2'b00, 2'b01, 1'b1, 4'h0); want[2] = 5'h02;
    cmds[3] = mk(2'b11, 2'b00, 1'b0, 4'h0); want[3] = 5'h02;
    cmds[4] = mk(2'b01, 2'b00, 1'b0, 4'h3); want[4] = 5'h03;
    cmds[5] = mk(2'b00, 2'b10, 1'b0, 4'h5); want[5] = 5'h1E;
    cmds[6] = mk(2'b00, 2'b11, 1'b0, 4'h7); want[6] = 5'h01;
    cmds[7] = mk(2'b00, 2'b00, 1'b0, 4'hF); want[7] = 5'h01;
    for (int i = 0; i < 8; i++) begin
      push(cmds[i], 20, acc);
      if (i == 2) begin
        // Carry-in path: acc=1, imm=0, use_carry with stored carry 1.
        for (int k = 0; k < 20; k++) begin
          @(negedge clk_i);
          if (res_valid_o) break;
        end
        n_vec++;
        if ({alu_a_o, alu_b_o, alu_cin_o, alu_opcode_o, alu_pass_a_o, alu_pass_b_o} !== {4'h1, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0}) begin
          n_miss++; $display("FAIL dir_alu_drive: got %h, required %h",
            {alu_a_o, alu_b_o, alu_cin_o, alu_opcode_o, alu_pass_a_o, alu_pass_b_o}, {4'h1, 4'h0, 1'b1, 2'b01, 1'b0, 1'b0});
        end
        @(posedge clk_i); #1;
      end
      collect(got, ok);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (ok) begin
        n_vec++;
        if (got !== want[i]) begin n_miss++; $display("FAIL dir_resp%0d: got %h, required %h", i, got, want[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit         exp_rdy [6] = '{1, 1, 1, 1, 1, 0};
    int         exp_cnt [6] = '{0, 1, 1, 2, 3, 4};
    logic [31:0] rnd;
    logic [4:0] got, want;
    bit         ok, seen;
    res_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rnd = $urandom();
      cmd_valid_i = 1'b1;
      cmd_data_i  = rnd[8:0];
      @(negedge clk_i);
      n_vec++;
      if (cmd_ready_o !== exp_rdy[k]) begin n_miss++; $display("FAIL bp_ready%0d: got %b, required %b", k, cmd_ready_o, exp_rdy[k]); end
      n_vec++;
      if (int'(dut.count_q) != exp_cnt[k]) begin n_miss++; $display("FAIL bp_count%0d: got %0d, required %0d", k, dut.count_q, exp_cnt[k]); end
      if (exp_rdy[k]) model_push(rnd[8:0]);
      @(posedge clk_i); #1;
    end
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (cmd_ready_o !== 1'b0) begin n_miss++; $display("FAIL bp_full_hold: got %b, required 0", cmd_ready_o); end
    @(posedge clk_i); #1;
    for (int r = 0; r < 5; r++) begin
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk_i);
        if (res_valid_o) begin seen = 1'b1; break; end
      end
      want = (exp_q.size() > 0) ? exp_q[0] : 5'h00;
      for (int s = 0; s < 2; s++) begin
        n_vec++;
        if (!seen || res_valid_o !== 1'b1 || {res_cout_o, res_data_o} !== want) begin
          n_miss++; $display("FAIL bp_stall%0d: valid %b data %h, required 1 / %h", r, res_valid_o, {res_cout_o, res_data_o}, want);
        end
        @(negedge clk_i);
      end
      @(posedge clk_i); #1;
      collect(got, ok);
      if (ok) begin
        n_vec++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h00;
        if (got !== want) begin n_miss++; $display("FAIL bp_resp%0d: got %h, required %h", r, got, want); end
      end
    end
  endtask

  task automatic test_random_wrap();
    int n = 4 * DEPTH;
    fork
      begin
        logic [31:0] rnd_p;
        bit acc;
        for (int i = 0; i < n; i++) begin
          rnd_p = $urandom();
          push(rnd_p[8:0], 200, acc);
          repeat ($urandom_range(0, 1)) @(posedge clk_i);
          #1;
        end
      end
      begin
        logic [4:0] got, want;
        bit ok;
        for (int j = 0; j < n; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk_i);
          #1;
          collect(got, ok);
          if (ok) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_miss++; $display("FAIL rand_resp%0d: got %h, required no response", j, got);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin n_miss++; $display("FAIL rand_resp%0d: got %h, required %h", j, got, want); end
            end
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    bit ok, acc, quiet;
    // Reset while DRIVE is active with one more command queued.
    push(mk(2'b01, 2'b00, 1'b0, 4'h9), 20, acc);
    push(mk(2'b10, 2'b00, 1'b0, 4'h0), 20, acc);
    n_vec++;
    if (alu_pass_b_o !== 1'b1 || alu_b_o !== 4'h9) begin n_miss++; $display("FAIL rm_drive_pre: pass_b %b b %h, required 1 / 9", alu_pass_b_o, alu_b_o); end
    assert_reset();
    #1;
    n_vec++;
    if (res_valid_o !== 1'b0 || {alu_a_o, alu_b_o, alu_cin_o, alu_opcode_o, alu_pass_a_o, alu_pass_b_o} !== 13'h0) begin
      n_miss++; $display("FAIL rm_drive_clear: valid %b alu %h, required 0 / 0", res_valid_o, {alu_a_o, alu_b_o, alu_cin_o, alu_opcode_o, alu_pass_a_o, alu_pass_b_o});
    end
    n_vec++;
    if (dut.count_q !== '0) begin n_miss++; $display("FAIL rm_fifo_empty: got %0d, required 0", dut.count_q); end
    release_reset();
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      if (res_valid_o !== 1'b0) quiet = 1'b0;
    end
    n_vec++;
    if (!quiet || cmd_ready_o !== 1'b1) begin n_miss++; $display("FAIL rm_quiet: quiet %b ready %b, required 1 / 1", quiet, cmd_ready_o); end
    @(posedge clk_i); #1;
    push(mk(2'b10, 2'b00, 1'b0, 4'h0), 20, acc);
    collect(got, ok);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (ok) begin
      n_vec++;
      if (got !== 5'h00) begin n_miss++; $display("FAIL rm_acc_zero: got %h, required 00", got); end
    end
    push(mk(2'b01, 2'b00, 1'b0, 4'h5), 20, acc);
    collect(got, ok);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (ok) begin
      n_vec++;
      if (got !== 5'h05) begin n_miss++; $display("FAIL rm_load5_a: got %h, required 05", got); end
    end
    // Reset while a response is held in RESP.
    push(mk(2'b01, 2'b00, 1'b0, 4'h7), 20, acc);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (res_valid_o) begin ok = 1'b1; break; end
    end
    n_vec++;
    if (!ok || alu_pass_b_o !== 1'b1 || alu_b_o !== 4'h7) begin n_miss++; $display("FAIL rm_resp_pre: valid %b b %h, required 1 / 7", ok, alu_b_o); end
    #2;
    assert_reset();
    #1;
    n_vec++;
    if (res_valid_o !== 1'b0 || {alu_a_o, alu_b_o, alu_cin_o, alu_opcode_o, alu_pass_a_o, alu_pass_b_o} !== 13'h0) begin
      n_miss++; $display("FAIL rm_resp_clear: valid %b alu %h, required 0 / 0", res_valid_o, {alu_a_o, alu_b_o, alu_cin_o, alu_opcode_o, alu_pass_a_o, alu_pass_b_o});
    end
    release_reset();
    push(mk(2'b01, 2'b00, 1'b0, 4'h5), 20, acc);
    collect(got, ok);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (ok) begin
      n_vec++;
      if (got !== 5'h05) begin n_miss++; $display("FAIL rm_load5_b: got %h, required 05", got); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
